// File: rtl/mm_collector_pkg.sv
// -----------------------------------------------------------------------------
// mm_collector_pkg
//
// Shared defaults and derived widths for the matmul result collector, and the
// collector FSM state type.
//
//   WIDTH        bits per element
//   TILE_ELEMS   elements per result tile from the systolic array
//   OUT_ELEMS    elements per output slice
//   TOTAL_TILES  tiles per attention head
//
// Derived:
//   SLICES       output slices per tile
//   SLICE_W      bits per output slice
//   TILE_W       bits per result tile
//   SLICE_IDX_W  width of the slice index (at least 1 bit)
//   TILE_CNT_W   width of the per-head tile counter (holds 0..TOTAL_TILES)
// -----------------------------------------------------------------------------
package mm_collector_pkg;

  localparam int WIDTH       = 16;
  localparam int TILE_ELEMS  = 16;
  localparam int OUT_ELEMS   = 4;
  localparam int TOTAL_TILES = 8;

  localparam int SLICES      = TILE_ELEMS / OUT_ELEMS;
  localparam int SLICE_W     = WIDTH * OUT_ELEMS;
  localparam int TILE_W      = WIDTH * TILE_ELEMS;
  localparam int SLICE_IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int TILE_CNT_W  = $clog2(TOTAL_TILES + 1);

  // RUN: collecting and streaming tiles of the current head.
  // DONE: every tile of the head has drained; waiting for clear.
  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } collector_state_t;

endpackage : mm_collector_pkg

// File: rtl/result_pingpong_bank.sv
// -----------------------------------------------------------------------------
// result_pingpong_bank
//
// Two-entry ping-pong tile store. Tiles are written into the bank selected by
// wr_sel and read from the bank selected by rd_sel; both pointers toggle, so
// the pair behaves as a two-deep FIFO of whole tiles.
//
// A write is accepted when the target bank is empty, or when it is the bank
// whose final slice is being released this very cycle (the freed slot is
// reused immediately, so a full pair never drops a tile that arrives in the
// release cycle).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous restart; empties both banks, resets pointers
//   wr_en        tile write request (caller gates it to the RUN state)
//   wr_tile      tile data to store
//   rd_release   final slice of the current read bank has handshaken
//   rd_tile      contents of the current read bank
//   rd_full      current read bank holds a tile
//   both_full    both banks hold a tile
//   wr_drop      wr_en could not be accepted this cycle
// -----------------------------------------------------------------------------
module result_pingpong_bank #(
  parameter int TILE_W = mm_collector_pkg::TILE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [TILE_W-1:0] wr_tile,
  input  logic              rd_release,
  output logic [TILE_W-1:0] rd_tile,
  output logic              rd_full,
  output logic              both_full,
  output logic              wr_drop
);

  logic [TILE_W-1:0] bank [2];
  logic [1:0]        full;
  logic              wr_sel;
  logic              rd_sel;
  logic              wr_accept;
  logic              target_freed;

  // The write target counts as free when the reader is releasing that same
  // bank in this cycle.
  assign target_freed = rd_release && (rd_sel == wr_sel);
  assign wr_accept    = wr_en && (!full[wr_sel] || target_freed);
  assign wr_drop      = wr_en && !wr_accept;

  assign rd_tile   = bank[rd_sel];
  assign rd_full   = full[rd_sel];
  assign both_full = full[0] & full[1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would let the release update leak into
  // the accept update within the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 2'b00;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else if (clear) begin
      full   <= 2'b00;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      if (rd_release) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
      end
      // Placed after the release so a same-bank refill leaves the flag set.
      if (wr_accept) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= ~wr_sel;
      end
    end
  end

  // NOTE: tile storage deliberately has no reset; the full flags alone say
  // whether a bank holds valid data, and leaving wide data flops unreset
  // keeps them off the reset tree.
  always_ff @(posedge clk) begin
    if (wr_accept && !clear) begin
      bank[wr_sel] <= wr_tile;
    end
  end

endmodule : result_pingpong_bank

// File: rtl/mm_result_collector.sv
// -----------------------------------------------------------------------------
// mm_result_collector
//
// Collects completed result tiles from the systolic matmul array into a
// two-entry ping-pong store and streams each tile to the next attention stage
// as OUT_ELEMS-element slices over a valid/ready interface. Tiles are counted
// per head; after TOTAL_TILES tiles have drained the block sits in DONE until
// clear starts the next head.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clear         synchronous restart for the next head (highest priority)
//   in_valid      tile strobe from the buffer controller
//   in_tile       result tile, element 0 in the LSBs
//   stall_req     both banks full; the controller must hold off new tiles
//   m_valid       output slice valid
//   m_ready       downstream accept
//   m_data        current slice, zero when m_valid is low
//   m_tile_last   current slice is the last of its tile
//   m_last        current slice is the last slice of the last tile of the head
//   done          all tiles of the head have drained (level)
//   overflow      sticky: at least one tile was dropped
// -----------------------------------------------------------------------------
module mm_result_collector #(
  parameter int WIDTH       = mm_collector_pkg::WIDTH,
  parameter int TILE_ELEMS  = mm_collector_pkg::TILE_ELEMS,
  parameter int OUT_ELEMS   = mm_collector_pkg::OUT_ELEMS,
  parameter int TOTAL_TILES = mm_collector_pkg::TOTAL_TILES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic [WIDTH*TILE_ELEMS-1:0] in_tile,
  output logic                        stall_req,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [WIDTH*OUT_ELEMS-1:0]  m_data,
  output logic                        m_tile_last,
  output logic                        m_last,
  output logic                        done,
  output logic                        overflow
);

  import mm_collector_pkg::*;

  localparam int SLICES      = TILE_ELEMS / OUT_ELEMS;
  localparam int SLICE_W     = WIDTH * OUT_ELEMS;
  localparam int TILE_W      = WIDTH * TILE_ELEMS;
  localparam int SLICE_IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int TILE_CNT_W  = $clog2(TOTAL_TILES + 1);

  localparam logic [SLICE_IDX_W-1:0] LAST_SLICE = SLICE_IDX_W'(SLICES - 1);
  localparam logic [TILE_CNT_W-1:0]  LAST_TILE  = TILE_CNT_W'(TOTAL_TILES - 1);

  // A tile must split into a whole number of slices.
  if ((TILE_ELEMS % OUT_ELEMS) != 0) begin : g_bad_slicing
    $error("mm_result_collector: TILE_ELEMS must be a multiple of OUT_ELEMS");
  end

  collector_state_t               state;
  logic [SLICE_IDX_W-1:0]         slice_idx;
  logic [TILE_CNT_W-1:0]          tile_cnt;

  logic [TILE_W-1:0]              rd_tile;
  logic [SLICES-1:0][SLICE_W-1:0] rd_slices;
  logic                           rd_full;
  logic                           both_full;
  logic                           wr_en;
  logic                           wr_drop;
  logic                           handshake;
  logic                           last_slice;
  logic                           rd_release;

  // Tiles are only accepted while the head is still running; anything that
  // arrives in DONE is counted as an overflow below.
  assign wr_en      = in_valid && (state == RUN);
  assign last_slice = (slice_idx == LAST_SLICE);
  assign handshake  = m_valid && m_ready;
  assign rd_release = handshake && last_slice;

  result_pingpong_bank #(
    .TILE_W (TILE_W)
  ) u_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .wr_en      (wr_en),
    .wr_tile    (in_tile),
    .rd_release (rd_release),
    .rd_tile    (rd_tile),
    .rd_full    (rd_full),
    .both_full  (both_full),
    .wr_drop    (wr_drop)
  );

  // View the read tile as an array of slices; slice 0 sits in the LSBs.
  assign rd_slices = rd_tile;

  assign m_valid     = rd_full;
  assign stall_req   = both_full;
  assign m_tile_last = m_valid && last_slice;
  assign m_last      = m_tile_last && (tile_cnt == LAST_TILE);
  assign done        = (state == DONE);

  // NOTE: every combinational output gets a default before any condition, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    m_data = '0;
    if (m_valid) begin
      m_data = rd_slices[slice_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      slice_idx <= '0;
      tile_cnt  <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      // Inputs and handshakes in the clear cycle are ignored entirely.
      state     <= RUN;
      slice_idx <= '0;
      tile_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (handshake) begin
        slice_idx <= last_slice ? '0 : slice_idx + 1'b1;
      end

      if (rd_release) begin
        tile_cnt <= tile_cnt + 1'b1;
        if ((state == RUN) && (tile_cnt == LAST_TILE)) begin
          state <= DONE;
        end
      end

      // Dropped because both banks stay full, or because the head is over.
      if (wr_drop || (in_valid && (state == DONE))) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule : mm_result_collector
